// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: eight-digit common-anode seven-segment scan controller with
// per-slot blanking, 16-step brightness and once-per-frame shadow capture.
`default_nettype none

module sevenseg_scan_ctrl #(
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] display_control,
  input  logic [63:0] sevenseg_data,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n,
  output logic        frame_strobe,
  output logic [2:0]  active_digit
);

  localparam int CW = $clog2(SCAN_DIV + 1);
  localparam int STEP = (SCAN_DIV - BLANK_CYCLES) >> 4;
  localparam logic [CW-1:0] LAST_W  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] STEP_W  = CW'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2,
    OFF   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    digit, digit_nxt;
  logic          load;
  logic          enable;
  logic [63:0]   sh_seg, sh_seg_nxt;
  logic [3:0]    sh_bright, bright_nxt;
  logic [7:0]    sh_mask, mask_nxt;
  logic [CW-1:0] lit_end;
  logic [7:0]    an_nxt, seg_nxt;
  logic          unused_ctrl;

  assign enable      = display_control[0];
  assign unused_ctrl = ^{display_control[31:16], display_control[3:1]};

  // Outputs are registered from next-cycle values so each output cycle matches
  // the counter/state that the same cycle holds.
  always_comb begin
    cnt_nxt   = '0;
    digit_nxt = '0;
    load      = 1'b0;
    if (enable) begin
      if (state == IDLE) begin
        load = 1'b1;
      end else if (cnt == LAST_W) begin
        digit_nxt = digit + 3'd1;
        load      = (digit == 3'd7);
      end else begin
        cnt_nxt   = cnt + CW'(1);
        digit_nxt = digit;
      end
    end

    sh_seg_nxt = load ? sevenseg_data         : sh_seg;
    bright_nxt = load ? display_control[7:4]  : sh_bright;
    mask_nxt   = load ? display_control[15:8] : sh_mask;

    lit_end = BLANK_W + STEP_W * CW'({1'b0, bright_nxt} + 5'd1);

    if (!enable)                state_nxt = IDLE;
    else if (cnt_nxt < BLANK_W) state_nxt = BLANK;
    else if (cnt_nxt < lit_end) state_nxt = ON;
    else                        state_nxt = OFF;

    an_nxt  = 8'hFF;
    seg_nxt = 8'hFF;
    if (state_nxt == ON) begin
      an_nxt[digit_nxt] = ~mask_nxt[digit_nxt];
      seg_nxt           = ~sh_seg_nxt[{digit_nxt, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      digit        <= '0;
      sh_seg       <= '0;
      sh_bright    <= '0;
      sh_mask      <= '0;
      an_n         <= 8'hFF;
      seg_n        <= 8'hFF;
      frame_strobe <= 1'b0;
      active_digit <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      digit        <= digit_nxt;
      sh_seg       <= sh_seg_nxt;
      sh_bright    <= bright_nxt;
      sh_mask      <= mask_nxt;
      an_n         <= an_nxt;
      seg_n        <= seg_nxt;
      frame_strobe <= load;
      active_digit <= digit_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: randomized scoreboard bench for sevenseg_scan_ctrl
// against a frame-time reference model.
`default_nettype none

module tb_sevenseg_scan_ctrl;

  localparam int SD     = 32;
  localparam int BL     = 4;
  localparam int PERIOD = 8 * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] display_control;
  logic [63:0] sevenseg_data;
  logic [7:0]  seg_n, an_n;
  logic        frame_strobe;
  logic [2:0]  active_digit;

  int checks   = 0;
  int failures = 0;

  logic [19:0] exp_q[$];

  sevenseg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .display_control(display_control),
    .sevenseg_data(sevenseg_data), .seg_n(seg_n), .an_n(an_n),
    .frame_strobe(frame_strobe), .active_digit(active_digit)
  );

  always #5 clk = ~clk;

  // Reference model: time since frame start determines digit and slot position.
  bit          run;
  int          t;
  logic [63:0] m_seg;
  logic [3:0]  m_br;
  logic [7:0]  m_mask;

  always @(posedge clk) begin
    logic       e_strobe;
    logic [2:0] e_dig;
    logic [7:0] e_an, e_seg;
    int         c, d, lit;
    if (!rst_n) begin
      run = 0; t = 0; m_seg = '0; m_br = '0; m_mask = '0;
      exp_q.delete();
    end else begin
      e_strobe = 1'b0; e_dig = 3'd0; e_an = 8'hFF; e_seg = 8'hFF;
      if (!display_control[0]) begin
        run = 0;
      end else begin
        if (!run) begin run = 1; t = 0; end
        else t = t + 1;
        if (t % PERIOD == 0) begin
          m_seg = sevenseg_data; m_br = display_control[7:4];
          m_mask = display_control[15:8]; e_strobe = 1'b1;
        end
        c   = t % SD;
        d   = (t / SD) % 8;
        lit = BL + ((SD - BL) / 16) * (int'(m_br) + 1);
        e_dig = 3'(d);
        if (c >= BL && c < lit) begin
          e_an[d] = ~m_mask[d];
          e_seg   = ~m_seg[d*8 +: 8];
        end
      end
      exp_q.push_back({e_strobe, e_dig, e_an, e_seg});
    end
  end

  always @(posedge clk) begin
    logic [19:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {frame_strobe, active_digit, an_n, seg_n};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scan_out t=%0t: got strobe=%b dig=%0d an_n=%h seg_n=%h, required strobe=%b dig=%0d an_n=%h seg_n=%h",
                 $time, a[19], a[18:16], a[15:8], a[7:0], e[19], e[18:16], e[15:8], e[7:0]);
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({frame_strobe, active_digit, an_n, seg_n} !== {1'b0, 3'd0, 8'hFF, 8'hFF}) begin
      failures++;
      $display("FAIL %s: got strobe=%b dig=%0d an_n=%h seg_n=%h, required 0 0 ff ff",
               name, frame_strobe, active_digit, an_n, seg_n);
    end
  endtask

  task automatic wait_lit(input int limit);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (an_n != 8'hFF) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_lit: an_n stayed %h, required a lit digit within %0d cycles", an_n, limit);
    end
  endtask

  task automatic wait_digit(input logic [2:0] dg, input int limit);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (active_digit == dg) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_digit: active_digit=%0d, required %0d within %0d cycles", active_digit, dg, limit);
    end
  endtask

  initial begin
    int brs[3];
    brs = '{0, 7, 15};
    rst_n = 1'b0;
    display_control = '0;
    sevenseg_data   = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    display_control = 32'h0000_FF01;
    sevenseg_data   = 64'h0706_0504_0302_0100;
    repeat (300) @(negedge clk);

    foreach (brs[i]) begin
      display_control = 32'h0000_FF01 | (32'(brs[i]) << 4);
      repeat (260) @(negedge clk);
    end

    display_control = 32'h0000_0571;
    repeat (260) @(negedge clk);

    display_control = 32'h0000_FFF1;
    wait_digit(3'd3, 300);
    sevenseg_data = {$urandom, $urandom};
    repeat (520) @(negedge clk);

    wait_lit(300);
    display_control[0] = 1'b0;
    repeat (5) @(negedge clk);
    display_control[0] = 1'b1;
    repeat (300) @(negedge clk);

    wait_lit(300);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(negedge clk);
    display_control[0] = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("post_reset_idle");
    display_control[0] = 1'b1;
    repeat (300) @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      display_control = $urandom;
      display_control[0] = ($urandom_range(0, 4) != 0);
      sevenseg_data = {$urandom, $urandom};
      repeat ($urandom_range(20, 300)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
